// File: rtl/alu_pipe_if.sv
// Execute-stage ALU bus: operation offer, result return, flush, and condition codes.
// The slave side is the ALU; the master side is the issuing/consuming pipeline.
interface alu_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_set_cc;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_of;
    logic [TAG_W-1:0] out_tag;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    modport master (
        output in_valid, in_a, in_b, in_op, in_set_cc, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_of, out_tag, cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_set_cc, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_of, out_tag, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-stage registered ALU (ADD/SUB/AND/XOR) with valid/ready backpressure,
// flush, pass-through tag and a ZF/SF/OF condition-code register.
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_of;
    logic [TAG_W-1:0] r_tag;
    logic             r_zf;
    logic             r_sf;
    logic             r_cc_of;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    op_e              w_op;

    assign w_op       = op_e'(bus.in_op);
    // Only flush, out_ready and the held-valid bit reach in_ready; operands never do.
    assign w_in_ready = !bus.flush && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = bus.in_a + bus.in_b;
                w_ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = bus.in_a - bus.in_b;
                w_ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_AND: w_res = bus.in_a & bus.in_b;
            OP_XOR: w_res = bus.in_a ^ bus.in_b;
            default: w_res = '0;
        endcase
    end

    // Result stage: a simultaneous transfer and accept simply reloads, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_of     <= 1'b0;
            r_tag    <= '0;
        end else if (bus.flush) begin
            r_valid  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_of     <= w_ovf;
            r_tag    <= bus.in_tag;
        end else if (r_valid && bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // Accept already excludes flush, so CC cannot move in a flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf    <= 1'b1;
            r_sf    <= 1'b0;
            r_cc_of <= 1'b0;
        end else if (w_accept && bus.in_set_cc) begin
            r_zf    <= (w_res == '0);
            r_sf    <= w_res[WIDTH-1];
            r_cc_of <= w_ovf;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_of     = r_of;
    assign bus.out_tag    = r_tag;
    assign bus.cc_zf      = r_zf;
    assign bus.cc_sf      = r_sf;
    assign bus.cc_of      = r_cc_of;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, parametrised-width integer ALU for the pipelined processor's execute stage. It supports ADD, SUB, AND and XOR with a single muxed result, not per-operation gated outputs. It adds a valid/ready handshake with backpressure, an architectural condition-code register (ZF/SF/OF), a pass-through destination tag, and a flush input for mispredict/bubble handling.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits (≥ 2)
- TAG_W, 4, width of the pass-through tag (destination register ID)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A, two's complement
- in_b  in  WIDTH  operand B, two's complement
- in_op  in  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 XOR
- in_set_cc  in  1  this operation updates the condition codes
- in_tag  in  TAG_W  carried unchanged to out_tag
- flush  in  1  kill the held result and refuse new input this cycle
- out_valid  out  1  out_result, out_of and out_tag are valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  operation result
- out_of  out  1  signed overflow of this result (0 for AND/XOR)
- out_tag  out  TAG_W  tag of this result
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register

## Operation
- One output register stage holds: valid_q, result, of, tag.
- in_ready = !flush && (!valid_q || out_ready). It is combinational from flush, out_ready and valid_q.
- Accept happens when in_valid && in_ready.
- Arithmetic is modulo 2^WIDTH:
  - ADD: R = A + B.
  - SUB: R = A − B.
  - AND: R = A & B.
  - XOR: R = A ^ B.
- Overflow, with s(x) = bit WIDTH−1:
  - ADD: OF = (s(A) == s(B)) && (s(R) != s(A)).
  - SUB: OF = (s(A) != s(B)) && (s(R) != s(A)).
  - AND/XOR: OF = 0.
- Next-state priority, highest first:
  1. rst: all registers go to reset values.
  2. flush: valid_q ← 0. No accept. CC unchanged. Result, of and tag registers are don't-care.
  3. accept: valid_q ← 1. Result, of and tag load from the new operation.
  4. out_valid && out_ready without accept: valid_q ← 0.
  5. otherwise: hold all registers.
- Condition codes:
  - Updated only on accept with in_set_cc = 1.
  - ZF ← (R == 0), SF ← s(R), OF ← computed OF.
  - Any other cycle, including flush, holds CC.
  - CC updates on the same edge as the result register, so new CC values become visible in the same cycle as out_valid for that operation.
- Output transfer: occurs when out_valid && out_ready. A transfer in a flush cycle still counts; the consumer has taken the result.
- Simultaneous transfer and accept (valid_q = 1, out_ready = 1, in_valid = 1, flush = 0): the new result replaces the old one with no bubble, giving full throughput.
- Reset values: out_valid 0, out_result 0, out_of 0, out_tag 0, cc_zf 1, cc_sf 0, cc_of 0. in_ready = 1 in the first cycle after reset if flush = 0.

## Timing
- Latency: 1 cycle. An operation accepted at edge N has out_valid = 1 in the cycle after edge N.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure: while out_valid = 1 and out_ready = 0:
  - in_ready = 0.
  - out_result, out_of and out_tag are held stable.
  - CC is held.
- out_valid and all data outputs come from registers. in_ready is the only combinational output.
- Reset mid-operation: a held result is discarded with no transfer. CC returns to its reset values (ZF = 1) on that edge.
- The implementation must have no combinational path from in_a, in_b or in_op to any output.

## Test plan
- ADD overflow, WIDTH = 64, set_cc = 1: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1 → next cycle out_result = 0x8000_0000_0000_0000, out_of = 1, cc_sf = 1, cc_zf = 0, cc_of = 1.
- SUB and logic, back-to-back with out_ready = 1:
  - 5 − 5 with set_cc = 1 → result 0, ZF = 1.
  - Then AND 0xF0 & 0x3C with set_cc = 0 → result 0x30, out_of = 0, CC still ZF = 1.
  - Then XOR 0xFF ^ 0x0F with set_cc = 1 → 0xF0, ZF = 0, SF = 0.
  - One result per cycle, tags 1, 2, 3 in order.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with a second operation (tag 7) pending → in_ready = 0, first result and tag stable, CC unchanged.
  - Release → first result transfers the same cycle; tag 7 result appears the next cycle.
- Flush: with result (tag 2) held and out_ready = 0, assert flush with in_valid = 1 and set_cc = 1 → in_ready = 0; next cycle out_valid = 0, the offered operation is never emitted, CC unchanged.
- Reset: after accepting SUB 0 − 1 (SF = 1, OF = 0), assert rst while out_valid = 1 → next cycle out_valid = 0, outputs 0, cc_zf = 1, cc_sf = 0, cc_of = 0.
- WIDTH = 8 build: ADD 0x80 + 0x80 → result 0x00, out_of = 1, ZF = 1; SUB 0x80 − 0x01 → 0x7F, out_of = 1.
